// File: rtl/comp_seq_ctrl_pkg.sv
// comp_seq_ctrl_pkg
// Shared definitions for the sequential cascade comparator controller.
//   - CMP_GT / CMP_EQ / CMP_LT : one-hot {gt,eq,lt} compare encodings
//   - state_t                  : controller states ST_IDLE, ST_RUN, ST_DONE
//   - is_one_hot3()            : true when a 3-bit value has exactly one bit set
//   - sanitize_cas()           : maps a non-one-hot cascade seed to CMP_EQ
package comp_seq_ctrl_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    // An illegal seed would otherwise ride the cascade all the way to the
    // result, so it is replaced by the neutral "equal" value.
    function automatic logic [2:0] sanitize_cas(input logic [2:0] v);
        return is_one_hot3(v) ? v : CMP_EQ;
    endfunction

endpackage

// File: rtl/comp_seq_ctrl_if.sv
// comp_seq_ctrl_if
// Handshake bundle between an operand producer / result consumer and the
// comp_seq_ctrl controller.
//   in_valid, a_in, b_in, cas_in : operand request from the producer
//   in_ready                     : controller can accept operands
//   out_valid, result            : compare result toward the consumer
//   out_ready                    : consumer accepts the result
//   busy                         : controller is working or holding a result
//   clear                        : synchronous abort of the current compare
// Modport master is the producer/consumer side, slave is the controller.
interface comp_seq_ctrl_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [2:0]       cas_in;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       result;
    logic             busy;
    logic             clear;

    modport master (
        output in_valid, a_in, b_in, cas_in, out_ready, clear,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, cas_in, out_ready, clear,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/comp_seq_ctrl_slice.sv
// comp_slice
// Combinational SLICE-bit cascade comparator slice.
//   a, b : operand slices
//   c    : incoming cascade {gt,eq,lt} from the less significant slices
//   f    : outgoing cascade; a differing slice decides, an equal slice
//          passes the lower-order verdict through unchanged
module comp_slice
    import comp_seq_ctrl_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       c,
    output logic [2:0]       f
);

    always_comb begin
        if (a > b) begin
            f = CMP_GT;
        end else if (a < b) begin
            f = CMP_LT;
        end else begin
            f = c;
        end
    end

endmodule

// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl
// Compares two WIDTH-bit operands over NSLICE cycles with a single SLICE-bit
// cascade comparator, least significant slice first. The running verdict is
// kept in a cascade register and fed back into the slice each cycle, so the
// most significant differing slice has the last word.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : comp_seq_ctrl_if.slave (operand / result handshakes, busy, clear)
// WIDTH must be an integer multiple of SLICE.
module comp_seq_ctrl
    import comp_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic          clk,
    input  logic          rst,
    comp_seq_ctrl_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t           state;
    state_t           next_state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       cas_reg;
    logic [2:0]       slice_f;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;

    logic             in_ready_o;
    logic             out_valid_o;
    logic             busy_o;

    assign a_slice = a_reg[idx*SLICE +: SLICE];
    assign b_slice = b_reg[idx*SLICE +: SLICE];

    comp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a (a_slice),
        .b (b_slice),
        .c (cas_reg),
        .f (slice_f)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. clear wins over every handshake on the same edge.
    always_comb begin
        next_state = state;
        if (bus.clear) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid)      next_state = ST_RUN;
                ST_RUN:  if (idx == LAST_IDX)   next_state = ST_DONE;
                ST_DONE: if (bus.out_ready)     next_state = ST_IDLE;
                default:                        next_state = ST_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, slice index and cascade register. Operands
    // are only sampled in IDLE and are otherwise held so the result stays
    // stable while DONE waits on the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            cas_reg <= CMP_EQ;
        end else if (bus.clear) begin
            idx     <= '0;
            cas_reg <= CMP_EQ;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.a_in;
                        b_reg   <= bus.b_in;
                        idx     <= '0;
                        cas_reg <= sanitize_cas(bus.cas_in);
                    end
                end
                ST_RUN: begin
                    cas_reg <= slice_f;
                    idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. result always shows the cascade register; only
    // out_valid tells the consumer when it is meaningful.
    always_comb begin
        in_ready_o  = (state == ST_IDLE);
        out_valid_o = (state == ST_DONE);
        busy_o      = (state == ST_RUN) || (state == ST_DONE);
    end

    assign bus.in_ready  = in_ready_o;
    assign bus.out_valid = out_valid_o;
    assign bus.busy      = busy_o;
    assign bus.result    = cas_reg;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb_comp_seq_ctrl
// Scoreboard bench for comp_seq_ctrl (WIDTH=16, SLICE=4). Directed vectors
// push hand-computed results into a queue; an independent monitor pops and
// compares on every result handshake and checks accept-to-valid latency.
module tb_comp_seq_ctrl;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    typedef struct {
        logic [2:0] res;
        int         acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   passes;
    exp_t sbQueue[$];
    logic prevOutValid;

    comp_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    comp_seq_ctrl #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Presents one operand pair at a negedge and holds it until accepted.
    // track=0 issues a compare that will be aborted, so nothing is expected.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] cas, input logic [2:0] exp,
                                 input bit track);
        int waitCycles;
        waitCycles    = 0;
        bus.a_in      = a;
        bus.b_in      = b;
        bus.cas_in    = cas;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 0, 1);
        end else if (track) begin
            sbQueue.push_back('{res: exp, acc: cyc + 1});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: samples 2 time units after each falling edge, away from both
    // the DUT clock edge and the moment the stimulus side changes inputs.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prevOutValid = 1'b0;
        end else begin
            if (bus.out_valid && !prevOutValid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    checkOutput("latency", cyc - sbQueue[0].acc, NSLICE);
                end
            end
            if (bus.out_valid && bus.out_ready && sbQueue.size() > 0) begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("result", int'(bus.result), int'(e.res));
            end
            prevOutValid = bus.out_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCycles;
        int ovSeen;
        checks        = 0;
        passes        = 0;
        prevOutValid  = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.cas_in    = 3'b010;
        bus.out_ready = 1'b1;
        bus.clear     = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready",  int'(bus.in_ready),  1);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_busy",      int'(bus.busy),      0);
        checkOutput("rst_result",    int'(bus.result),    3'b010);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed compares");
        applyStimulus(16'h1234, 16'h1234, 3'b010, 3'b010, 1);
        applyStimulus(16'h8000, 16'h7FFF, 3'b010, 3'b100, 1);
        applyStimulus(16'h00F0, 16'h00F1, 3'b010, 3'b001, 1);
        applyStimulus(16'hABCD, 16'hABCD, 3'b100, 3'b100, 1);
        applyStimulus(16'hABCD, 16'hABCD, 3'b110, 3'b010, 1);
        applyStimulus(16'hABCD, 16'hABCD, 3'b000, 3'b010, 1);
        applyStimulus(16'hABCD, 16'hABCD, 3'b001, 3'b001, 1);
        applyStimulus(16'hA5A5, 16'hA5A4, 3'b001, 3'b100, 1);
        applyStimulus(16'h0F00, 16'h1000, 3'b010, 3'b001, 1);

        $display("[TB] backpressure");
        waitCycles = 0;
        while (!bus.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        bus.out_ready = 1'b0;
        applyStimulus(16'h0005, 16'h0003, 3'b010, 3'b100, 1);
        waitCycles = 0;
        while (!bus.out_valid && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("bp_reach_done", int'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", int'(bus.out_valid), 1);
            checkOutput("bp_result",    int'(bus.result),    3'b100);
            checkOutput("bp_in_ready",  int'(bus.in_ready),  0);
            bus.in_valid = (i % 2 == 0);
            bus.a_in     = 16'h0000;
            bus.b_in     = 16'hFFFF;
            bus.cas_in   = 3'b001;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("bp_hold_result", int'(bus.result),   3'b100);
        checkOutput("bp_no_turnaround", int'(bus.in_ready), 0);
        @(negedge clk);
        checkOutput("bp_in_ready_after", int'(bus.in_ready), 1);
        applyStimulus(16'h1000, 16'h0FFF, 3'b010, 3'b100, 1);

        $display("[TB] clear during RUN");
        waitCycles = 0;
        while (!bus.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        applyStimulus(16'h1234, 16'h0000, 3'b010, 3'b000, 0);
        repeat (2) @(negedge clk);
        checkOutput("clr_busy_before", int'(bus.busy), 1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checkOutput("clr_in_ready", int'(bus.in_ready),  1);
        checkOutput("clr_busy",     int'(bus.busy),      0);
        checkOutput("clr_result",   int'(bus.result),    3'b010);
        ovSeen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) ovSeen++;
            @(negedge clk);
        end
        checkOutput("clr_no_out_valid", ovSeen, 0);

        $display("[TB] async reset during RUN");
        applyStimulus(16'h00FF, 16'h0000, 3'b100, 3'b000, 0);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_in_ready",  int'(bus.in_ready),  1);
        checkOutput("arst_out_valid", int'(bus.out_valid), 0);
        checkOutput("arst_busy",      int'(bus.busy),      0);
        checkOutput("arst_result",    int'(bus.result),    3'b010);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(16'h0001, 16'h0000, 3'b010, 3'b100, 1);

        waitCycles = 0;
        while (sbQueue.size() > 0 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", sbQueue.size(), 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
